// File: rtl/mmio_timer.sv
// Bus-mapped 32-bit timer: CTRL/COUNT/COMPARE/STATUS, sticky MATCH, level irq.
// Optional prescaler (CTRL[31:16]) is built only when MMIO_TIMER_PRESCALE_EN is defined.
module mmio_timer #(
  parameter int unsigned PRESCALE_W  = 16,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_COUNT  = 2'd1;
  localparam logic [1:0] A_CMP    = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d;
  logic        match_q, match_d, irq_q;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic [31:0] ctrl_rd, ctrl_wv, count_tick;
  logic        wr, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic        tick, hit, clr_match;
  logic        unused_bits;

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
`endif

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign wr        = ce & we;
  assign wr_ctrl   = wr & (addr[3:2] == A_CTRL);
  assign wr_count  = wr & (addr[3:2] == A_COUNT);
  assign wr_cmp    = wr & (addr[3:2] == A_CMP);
  assign wr_status = wr & (addr[3:2] == A_STATUS);

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = auto_q;
    ctrl_rd[2] = ie_q;
`ifdef MMIO_TIMER_PRESCALE_EN
    ctrl_rd[16 +: PRESCALE_W] = presc_q;
`endif
  end

  assign ctrl_wv = lane_merge(ctrl_rd, data_i, sel);
  assign en_d    = wr_ctrl ? ctrl_wv[0] : en_q;
  assign auto_d  = wr_ctrl ? ctrl_wv[1] : auto_q;
  assign ie_d    = wr_ctrl ? ctrl_wv[2] : ie_q;

  // A CTRL write that drops EN suppresses the tick on that same edge.
`ifdef MMIO_TIMER_PRESCALE_EN
  assign presc_d = wr_ctrl ? ctrl_wv[16 +: PRESCALE_W] : presc_q;
  assign tick    = en_q & en_d & (pcnt_q == presc_q);
  assign pcnt_d  = (en_q & en_d & ~tick) ? pcnt_q + PRESCALE_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = en_q & en_d;
`endif

  assign hit        = tick & (count_q == compare_q);
  assign count_tick = !tick ? count_q : ((hit & auto_q) ? 32'd0 : count_q + 32'd1);
  assign count_d    = wr_count ? lane_merge(count_tick, data_i, sel) : count_tick;
  assign compare_d  = wr_cmp ? lane_merge(compare_q, data_i, sel) : compare_q;
  assign clr_match  = wr_status & sel[0] & data_i[0];
  assign match_d    = hit | (match_q & ~clr_match);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      irq_q     <= match_d & ie_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      case (addr[3:2])
        A_CTRL:   data_o = ctrl_rd;
        A_COUNT:  data_o = count_q;
        A_CMP:    data_o = compare_q;
        default:  data_o = {31'd0, match_q};
      endcase
    end
  end

  assign unused_bits = ^{addr, ctrl_wv};

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed bench for mmio_timer against a register-level reference model.
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        reset_n, ce, we;
  logic [3:0]  sel;
  logic [31:0] addr, data_i, data_o;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int unsigned PS_MASK = 32'h0000_FFFF;

  mmio_timer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ce     (ce),
    .we     (we),
    .sel    (sel),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .irq    (irq)
  );

  initial forever #5 clk = ~clk;

  // Reference model state, updated once per rising edge.
  bit          m_valid = 1'b0;
  bit          m_en, m_auto, m_ie, m_match;
  int unsigned m_ps, m_pcnt;
  bit [31:0]   m_count, m_cmp;

  function automatic bit [31:0] put_bytes(bit [31:0] old_v, bit [31:0] new_v, bit [3:0] be);
    bit [31:0] r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r = (r & ~(32'hFF << (8 * i))) | (new_v & (32'hFF << (8 * i)));
    return r;
  endfunction

  function automatic bit [31:0] m_ctrl();
    bit [31:0] v = {29'd0, m_ie, m_auto, m_en};
`ifdef MMIO_TIMER_PRESCALE_EN
    v = v | (m_ps << 16);
`endif
    return v;
  endfunction

  function automatic bit [31:0] m_read(bit [1:0] a);
    case (a)
      2'd0:    return m_ctrl();
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  always @(posedge clk) begin
    bit        wr, en_n, tick, hit;
    bit [1:0]  a;
    bit [31:0] c, cnt;
    if (reset_n !== 1'b1) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_match = 0;
      m_ps = 0; m_pcnt = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
      m_valid = 1;
    end else if (m_valid) begin
      wr   = ce && we;
      a    = addr[3:2];
      c    = (wr && a == 2'd0) ? put_bytes(m_ctrl(), data_i, sel) : m_ctrl();
      en_n = c[0];
`ifdef MMIO_TIMER_PRESCALE_EN
      tick = m_en && en_n && (m_pcnt == m_ps);
`else
      tick = m_en && en_n;
`endif
      hit = tick && (m_count == m_cmp);
      cnt = m_count;
      if (tick) cnt = (hit && m_auto) ? 32'd0 : m_count + 32'd1;
      if (wr && a == 2'd1) cnt = put_bytes(cnt, data_i, sel);
      if (wr && a == 2'd2) m_cmp = put_bytes(m_cmp, data_i, sel);
      if (hit) m_match = 1;
      else if (wr && a == 2'd3 && sel[0] && data_i[0]) m_match = 0;
      m_pcnt  = (tick || !en_n || !m_en) ? 0 : ((m_pcnt + 1) & PS_MASK);
      m_count = cnt;
      m_en    = c[0];
      m_auto  = c[1];
      m_ie    = c[2];
`ifdef MMIO_TIMER_PRESCALE_EN
      m_ps = c[31:16] & PS_MASK;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_irq", {31'd0, irq}, {31'd0, m_match & m_ie});
      chk("model_data_o", data_o, (ce === 1'b1 && we === 1'b0) ? m_read(addr[3:2]) : 32'd0);
    end
  end

  task automatic cyc(input bit c, input bit w, input bit [3:0] s, input bit [1:0] a, input bit [31:0] d);
    @(posedge clk);
    #2;
    ce     = c;
    we     = w;
    sel    = s;
    addr   = ($urandom & 32'hFFFF_FFF3) | (32'(a) << 2);
    data_i = d;
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    cyc(1'b1, 1'b1, 4'hF, a, d);
  endtask

  task automatic rd(input bit [1:0] a, input bit [31:0] exp, input string name);
    cyc(1'b1, 1'b0, 4'($urandom), a, $urandom);
    @(negedge clk);
    chk(name, data_o, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 4'hF, 2'($urandom), $urandom);
  endtask

`ifdef MMIO_TIMER_PRESCALE_EN
  localparam logic [31:0] EXP_PS_COUNT = 32'd2;
  localparam logic [31:0] EXP_PS_CTRL  = 32'h0003_0001;
`else
  localparam logic [31:0] EXP_PS_COUNT = 32'd8;
  localparam logic [31:0] EXP_PS_CTRL  = 32'h0000_0001;
`endif

  initial begin
    bit [1:0]  a;
    bit [31:0] d;
    reset_n = 0; ce = 0; we = 0; sel = 0; addr = 0; data_i = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;

    rd(0, 32'h0, "rst_ctrl");
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(1, 32'h0, "rst_count");
    rd(2, 32'hFFFF_FFFF, "rst_compare");
    rd(3, 32'h0, "rst_status");

    wr(2, 32'h1122_3344);
    cyc(1, 1, 4'b0101, 2, 32'hAABB_CCDD);
    rd(2, 32'h11BB_33DD, "byte_lanes");
    cyc(0, 0, 4'hF, 2, 32'h0);
    @(negedge clk);
    chk("ce_low_data", data_o, 32'h0);

    wr(1, 0); wr(2, 3); wr(0, 32'h7);
    rd(1, 32'd0, "en_edge_count");
    rd(1, 32'd1, "count_1");
    rd(1, 32'd2, "count_2");
    rd(1, 32'd3, "count_3");
    rd(1, 32'd0, "auto_reload");
    chk("match_irq", {31'd0, irq}, 32'd1);
    wr(3, 1);
    idle(1);
    @(negedge clk);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    wr(0, 0);

    wr(2, 32'hFFFF_0000); wr(1, 0); wr(0, 32'h0003_0001);
    idle(8);
    rd(1, EXP_PS_COUNT, "prescale_count");
    rd(0, EXP_PS_CTRL, "prescale_ctrl");
    wr(0, 0);

    wr(3, 1); wr(1, 32'hFFFF_FFFF); wr(2, 5); wr(0, 1);
    rd(1, 32'hFFFF_FFFF, "pre_wrap");
    rd(1, 32'h0, "wrap");
    rd(3, 32'h0, "wrap_nomatch");
    wr(0, 0);

    wr(1, 0); wr(0, 1);
    idle(1);
    wr(1, 32'h10);
    rd(1, 32'h10, "write_vs_tick");
    rd(1, 32'h11, "after_write_tick");
    wr(0, 0);

    wr(3, 1); wr(2, 3); wr(1, 0); wr(0, 32'h3);
    idle(3);
    wr(3, 1);
    rd(3, 32'h1, "w1c_vs_set");
    wr(0, 0); wr(3, 1);

    wr(1, 95); wr(0, 1);
    idle(5);
    @(posedge clk);
    #2;
    reset_n = 0; ce = 1; we = 1; sel = 4'hF; addr = 32'h4; data_i = 32'h55;
    @(posedge clk);
    #2;
    reset_n = 1; ce = 0; we = 0;
    rd(0, 32'h0, "midrst_ctrl");
    rd(1, 32'h0, "midrst_count");
    rd(2, 32'hFFFF_FFFF, "midrst_compare");
    rd(3, 32'h0, "midrst_status");
    idle(3);
    rd(1, 32'h0, "midrst_stopped");

    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      reset_n = ($urandom_range(0, 299) != 0);
      ce      = 1'($urandom_range(0, 1));
      we      = ($urandom_range(0, 9) < 6);
      sel     = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      a       = 2'($urandom);
      case (a)
        2'd0:    d = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 3) << 1)
                     | 32'($urandom_range(0, 3) != 0);
        2'd1:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                 : $urandom_range(0, 12);
        2'd2:    d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      addr   = ($urandom & 32'hFFFF_FFF3) | (32'(a) << 2);
      data_i = d;
    end
    reset_n = 1;
    idle(2);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that sits on the CPU data-memory bus as a responder, alongside the data RAM. It accepts chip-enable, write-enable, byte-select, address and write data from the core, and returns load data on the same bus. It runs a free-running or auto-reloading 32-bit counter with a compare register, a sticky match flag and a level interrupt. All state is clocked on `clk`; reset is synchronous.

## Interface
- `PRESCALE_W`, 16: width of the prescaler field in CTRL; max 16.
- `COMPARE_RST`, 32'hFFFF_FFFF: reset value of COMPARE.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `ce` input 1: bus access strobe, already address-decoded by the SOPC.
- `we` input 1: 1 = write, 0 = read; ignored when `ce`=0.
- `sel` input 4: byte enables; `sel[i]` covers `data_i[8i+7:8i]`.
- `addr` input 32: byte address; only `addr[3:2]` decoded; other bits ignored.
- `data_i` input 32: write data.
- `data_o` output 32: read data, combinational.
- `irq` output 1: interrupt request, level, active-high.

## Operation
- Register map (`addr[3:2]`):
  - 0 CTRL: [0] EN, [1] AUTO (reload to 0 on match), [2] IE, [31:16] PRESCALE. Other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: [0] MATCH, sticky; write 1 clears it (W1C); write 0 has no effect. Other bits read 0.
- Writes take effect when `ce`=1 and `we`=1, on the rising edge, per byte lane where `sel[i]`=1. Lanes with `sel[i]`=0 keep their old value.
- Reads: when `ce`=1 and `we`=0, `data_o` = the selected register (full 32 bits, regardless of `sel`). Otherwise `data_o` = 0.
- Prescaler:
  - Internal counter `pcnt` counts 0..PRESCALE while EN=1.
  - `tick` = EN & (`pcnt`==PRESCALE); `pcnt` wraps to 0 on tick.
  - `pcnt` is held at 0 while EN=0.
- On tick:
  - If COUNT==COMPARE: MATCH←1, and COUNT←0 if AUTO=1, else COUNT←COUNT+1.
  - Otherwise COUNT←COUNT+1.
  - COUNT wraps 0xFFFF_FFFF→0 with no flag.
- `irq` = MATCH & IE, taken directly from registers (glitch-free).
- Simultaneous events:
  - Bus write to COUNT and tick in the same cycle: the written bytes win; unwritten bytes take the tick result. The match check uses the pre-write COUNT.
  - W1C of MATCH and a new match in the same cycle: set wins.
  - A write to CTRL that clears EN takes effect at that edge: no tick occurs and `pcnt` is reset.
  - A write to COMPARE in the same cycle as a tick: the match check uses the old COMPARE.

## Timing
- Reset (`reset_n`=0 at an edge): CTRL=0, COUNT=0, COMPARE=COMPARE_RST, MATCH=0, `pcnt`=0.
- Outputs during reset: `irq`=0; `data_o` stays combinational (0 unless a read is presented).
- Reset mid-operation overrides any concurrent bus write.
- Write latency: the register updates at the edge where `ce`&`we` is sampled; a read in the next cycle returns the new value.
- Read latency: zero cycles. `data_o` is valid in the same cycle as `ce`, which matches the MEM-stage load timing. No wait states, no handshake.
- With PRESCALE=P, COUNT advances once every P+1 cycles. The first tick comes P+1 edges after the edge that sets EN.
- `irq` rises one edge after the match tick (same edge MATCH sets) and falls at the edge of the W1C write or the write clearing IE.

## Configuration
- `MMIO_TIMER_PRESCALE_EN` defined:
  - Prescaler logic present.
  - CTRL[31:16] is writable and readable.
  - Only the low PRESCALE_W bits are stored; upper unused bits read 0.
- `MMIO_TIMER_PRESCALE_EN` undefined:
  - No `pcnt` register; `tick` = EN.
  - CTRL[31:16] ignores writes and reads 0.

## Test plan
- Reset defaults: assert `reset_n`=0 for 2 cycles, then read all four registers → 0, 0, 0xFFFF_FFFF, 0; `irq`=0.
- Byte-lane write: write COMPARE=0x1122_3344 with `sel`=4'b1111, then write 0xAABB_CCDD with `sel`=4'b0101 → reads 0x11BB_33DD. With `ce`=0, `data_o`=0.
- Match with auto-reload and prescale 0:
  - Setup: COUNT=0, COMPARE=3, IE=1, then CTRL=0x7.
  - COUNT reads 1, 2, 3 on successive cycles.
  - On the 4th edge, MATCH=1, `irq`=1, COUNT=0.
  - Write STATUS=1 → `irq`=0 at the next edge.
- Prescaler (macro on): CTRL=0x0003_0001 from COUNT=0 → COUNT increments every 4 cycles; reads 2 after 8 cycles. With the macro off, the same stimulus gives COUNT=8 and CTRL reads 0x1.
- Collisions:
  - COUNT=0xFFFF_FFFF, COMPARE=5, EN=1 → COUNT wraps to 0 with no MATCH.
  - Bus write COUNT=0x10 coincident with a tick → COUNT reads 0x10.
  - W1C coincident with a new match → MATCH stays 1.
- Reset mid-run: EN=1, COUNT≈100, pulse `reset_n` low for one edge together with a COUNT write → all registers at their reset values; counting stops.
